param_shift_register: RTL and testbench

Parametrised successor to the single-bit, fixed-depth shift register. It is a WIDTH-bit by DEPTH-stage shift register with the following features:
- shift enable
- runtime shift direction
- parallel load
- synchronous flush
- full parallel tap output
- fill-level tracking

It is used as a generic delay line, serialiser and deserialiser in the basic block library. It is driven by the standard generated test harness.

---
 rtl/param_shift_register.sv | 113 +++++++++++
 tb/tb_param_shift_register.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/param_shift_register.sv
// param_shift_register: WIDTH-bit x DEPTH-stage bidirectional shift register
// with shift enable, parallel load, synchronous flush, full tap output and a
// saturating fill-level counter.
//
// Optional build macro SHREG_ROTATE_EN adds input io_rot. When it is set, an
// enabled shift feeds the outgoing word back into the input end, and the fill
// level is left unchanged.
//
// Port names follow the standard generated test harness (clock/reset/io_*).
// reset is synchronous and active-low.

module param_shift_register #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_en,
  input  logic                     io_dir,
  input  logic [WIDTH-1:0]         io_in,
  input  logic                     io_load,
  input  logic [WIDTH*DEPTH-1:0]   io_pload,
  input  logic                     io_flush,
`ifdef SHREG_ROTATE_EN
  input  logic                     io_rot,
`endif
  output logic [WIDTH-1:0]         io_out,
  output logic [WIDTH*DEPTH-1:0]   io_taps,
  output logic [CNT_W-1:0]         io_fill,
  output logic                     io_full
);

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

  // stage_q[i] is stage i; the packed layout matches io_pload/io_taps slicing
  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [DEPTH-1:0][WIDTH-1:0] shifted;
  logic [CNT_W-1:0]            fill_q, fill_d;
  logic [WIDTH-1:0]            out_word;
  logic [WIDTH-1:0]            in_word;
  logic                        rot_en;

`ifdef SHREG_ROTATE_EN
  assign rot_en = io_rot;
`else
  assign rot_en = 1'b0;
`endif

  // Exit-end word; follows io_dir combinationally (DEPTH=1 collapses to s[0])
  always_comb begin
    out_word = io_dir ? stage_q[0] : stage_q[DEPTH-1];
  end

  // Word entering the input end: serial input, or the exiting word when rotating
  always_comb begin
    in_word = rot_en ? out_word : io_in;
  end

  // One-position move of every stage in the selected direction
  always_comb begin
    shifted = stage_q;
    if (!io_dir) begin
      shifted[0] = in_word;
      for (int i = 1; i < DEPTH; i++) begin
        shifted[i] = stage_q[i-1];
      end
    end else begin
      shifted[DEPTH-1] = in_word;
      for (int i = 0; i < DEPTH - 1; i++) begin
        shifted[i] = stage_q[i+1];
      end
    end
  end

  // Next-state selection; flush beats load beats shift, otherwise hold
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (io_flush) begin
      stage_d = '0;
      fill_d  = '0;
    end else if (io_load) begin
      stage_d = io_pload;
      fill_d  = FILL_MAX;
    end else if (io_en) begin
      stage_d = shifted;
      if (!rot_en && (fill_q != FILL_MAX)) begin
        fill_d = fill_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset overriding everything
  always_ff @(posedge clock) begin
    if (!reset) begin
      stage_q <= '0;
      fill_q  <= '0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
    end
  end

  // Observation ports driven purely from state (io_out also from io_dir)
  always_comb begin
    io_out  = out_word;
    io_taps = stage_q;
    io_fill = fill_q;
    io_full = (fill_q == FILL_MAX);
  end

endmodule

// File: tb/tb_param_shift_register.sv
module tb_param_shift_register;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   clock;
  logic                   reset;
  logic                   io_en;
  logic                   io_dir;
  logic [WIDTH-1:0]       io_in;
  logic                   io_load;
  logic [WIDTH*DEPTH-1:0] io_pload;
  logic                   io_flush;
`ifdef SHREG_ROTATE_EN
  logic                   io_rot;
`endif
  logic [WIDTH-1:0]       io_out;
  logic [WIDTH*DEPTH-1:0] io_taps;
  logic [CNT_W-1:0]       io_fill;
  logic                   io_full;

  int pass_cnt = 0;
  int total_cnt = 0;

  param_shift_register #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_en    (io_en),
    .io_dir   (io_dir),
    .io_in    (io_in),
    .io_load  (io_load),
    .io_pload (io_pload),
    .io_flush (io_flush),
`ifdef SHREG_ROTATE_EN
    .io_rot   (io_rot),
`endif
    .io_out   (io_out),
    .io_taps  (io_taps),
    .io_fill  (io_fill),
    .io_full  (io_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance one rising edge, then settle before sampling/driving
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io_en = 1'b0; io_dir = 1'b0; io_in = '0;
    io_load = 1'b0; io_pload = '0; io_flush = 1'b0;
`ifdef SHREG_ROTATE_EN
    io_rot = 1'b0;
`endif
    step();
    step();
    reset = 1'b1;
    step();
    total_cnt++; if (io_out !== 8'h00) $display("FAIL reset_out got %h want %h", io_out, 8'h00); else pass_cnt++;
    total_cnt++; if (io_taps !== 32'h0) $display("FAIL reset_taps got %h want %h", io_taps, 32'h0); else pass_cnt++;
    total_cnt++; if (io_fill !== 3'd0) $display("FAIL reset_fill got %0d want 0", io_fill); else pass_cnt++;
    total_cnt++; if (io_full !== 1'b0) $display("FAIL reset_full got %b want 0", io_full); else pass_cnt++;
  endtask

  task automatic test_right_shift();
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    io_dir = 1'b0;
    io_en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io_in = words[i];
      step();
    end
    io_en = 1'b0;
    total_cnt++; if (io_taps !== 32'h11223344) $display("FAIL rshift_taps got %h want %h", io_taps, 32'h11223344); else pass_cnt++;
    total_cnt++; if (io_out !== 8'h11) $display("FAIL rshift_out got %h want %h", io_out, 8'h11); else pass_cnt++;
    total_cnt++; if (io_fill !== 3'd4) $display("FAIL rshift_fill got %0d want 4", io_fill); else pass_cnt++;
    total_cnt++; if (io_full !== 1'b1) $display("FAIL rshift_full got %b want 1", io_full); else pass_cnt++;
  endtask

  task automatic test_dir_flip();
    io_dir = 1'b1;
    io_in  = 8'h55;
    io_en  = 1'b1;
    step();
    io_en = 1'b0;
    total_cnt++; if (io_taps !== 32'h55112233) $display("FAIL flip_taps got %h want %h", io_taps, 32'h55112233); else pass_cnt++;
    total_cnt++; if (io_out !== 8'h33) $display("FAIL flip_out got %h want %h", io_out, 8'h33); else pass_cnt++;
    total_cnt++; if (io_fill !== 3'd4) $display("FAIL flip_fill got %0d want 4", io_fill); else pass_cnt++;
  endtask

  task automatic test_saturate();
    io_dir = 1'b1;
    io_in  = 8'h66;
    io_en  = 1'b1;
    step();
    io_en = 1'b0;
    total_cnt++; if (io_taps !== 32'h66551122) $display("FAIL sat_taps got %h want %h", io_taps, 32'h66551122); else pass_cnt++;
    total_cnt++; if (io_fill !== 3'd4) $display("FAIL sat_fill got %0d want 4", io_fill); else pass_cnt++;
    total_cnt++; if (io_full !== 1'b1) $display("FAIL sat_full got %b want 1", io_full); else pass_cnt++;
  endtask

  task automatic test_priority();
    io_flush = 1'b0;
    io_pload = 32'hA3A2A1A0;
    io_load  = 1'b1;
    io_en    = 1'b1;
    io_dir   = 1'b0;
    io_in    = 8'hEE;
    step();
    total_cnt++; if (io_taps !== 32'hA3A2A1A0) $display("FAIL load_taps got %h want %h", io_taps, 32'hA3A2A1A0); else pass_cnt++;
    total_cnt++; if (io_fill !== 3'd4) $display("FAIL load_fill got %0d want 4", io_fill); else pass_cnt++;
    io_flush = 1'b1;
    io_pload = 32'h5A5A5A5A;
    step();
    io_flush = 1'b0;
    io_load  = 1'b0;
    io_en    = 1'b0;
    total_cnt++; if (io_taps !== 32'h0) $display("FAIL flush_taps got %h want %h", io_taps, 32'h0); else pass_cnt++;
    total_cnt++; if (io_fill !== 3'd0) $display("FAIL flush_fill got %0d want 0", io_fill); else pass_cnt++;
    total_cnt++; if (io_full !== 1'b0) $display("FAIL flush_full got %b want 0", io_full); else pass_cnt++;
  endtask

  task automatic test_hold();
    io_dir = 1'b0;
    io_en  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      io_in = 8'(i);
      step();
    end
    io_en = 1'b0;
    total_cnt++; if (io_taps !== 32'h00010203) $display("FAIL part_taps got %h want %h", io_taps, 32'h00010203); else pass_cnt++;
    total_cnt++; if (io_fill !== 3'd3) $display("FAIL part_fill got %0d want 3", io_fill); else pass_cnt++;
    total_cnt++; if (io_full !== 1'b0) $display("FAIL part_full got %b want 0", io_full); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      io_in  = 8'hC0 + 8'(c);
      io_dir = c[0];
      step();
      total_cnt++; if (io_fill !== 3'd3) $display("FAIL hold_fill cyc %0d got %0d want 3", c, io_fill); else pass_cnt++;
      total_cnt++; if (io_taps !== 32'h00010203) $display("FAIL hold_taps cyc %0d got %h want %h", c, io_taps, 32'h00010203); else pass_cnt++;
    end
    io_dir = 1'b0;
    #1;
    total_cnt++; if (io_out !== 8'h00) $display("FAIL out_dir0 got %h want %h", io_out, 8'h00); else pass_cnt++;
    io_dir = 1'b1;
    #1;
    total_cnt++; if (io_out !== 8'h03) $display("FAIL out_dir1 got %h want %h", io_out, 8'h03); else pass_cnt++;
  endtask

  task automatic test_midstream_reset();
    io_dir = 1'b0;
    io_in  = 8'h77;
    io_en  = 1'b1;
    reset  = 1'b0;
    step();
    io_en = 1'b0;
    reset = 1'b1;
    total_cnt++; if (io_taps !== 32'h0) $display("FAIL mrst_taps got %h want %h", io_taps, 32'h0); else pass_cnt++;
    total_cnt++; if (io_fill !== 3'd0) $display("FAIL mrst_fill got %0d want 0", io_fill); else pass_cnt++;
    total_cnt++; if (io_out !== 8'h00) $display("FAIL mrst_out got %h want %h", io_out, 8'h00); else pass_cnt++;
  endtask

`ifdef SHREG_ROTATE_EN
  task automatic test_rotate();
    io_pload = 32'hA3A2A1A0;
    io_load  = 1'b1;
    step();
    io_load = 1'b0;
    io_dir  = 1'b0;
    io_rot  = 1'b1;
    io_en   = 1'b1;
    io_in   = 8'hFF;
    step();
    total_cnt++; if (io_taps !== 32'hA2A1A0A3) $display("FAIL rot1_taps got %h want %h", io_taps, 32'hA2A1A0A3); else pass_cnt++;
    for (int i = 0; i < 3; i++) step();
    io_en  = 1'b0;
    io_rot = 1'b0;
    total_cnt++; if (io_taps !== 32'hA3A2A1A0) $display("FAIL rot4_taps got %h want %h", io_taps, 32'hA3A2A1A0); else pass_cnt++;
    total_cnt++; if (io_fill !== 3'd4) $display("FAIL rot_fill got %0d want 4", io_fill); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_right_shift();
    test_dir_flip();
    test_saturate();
    test_priority();
    test_hold();
    test_midstream_reset();
`ifdef SHREG_ROTATE_EN
    test_rotate();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
